// File: rtl/ps2_key_tracker_if.sv
// Bundle between the PS/2 key tracker and its neighbours: the raw keyboard
// lines coming in, and the per-key held levels plus byte strobes going out.
interface ps2_key_tracker_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       W_Press, A_Press, S_Press, D_Press;
  logic       UpArrow_Press, RightArrow_Press, LeftArrow_Press, DownArrow_Press;
  logic       Enter_Press, F_Press, R_Press, T_Press;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  // Keyboard / stimulus side.
  modport master (
    output ps2_clk, ps2_data,
    input  W_Press, A_Press, S_Press, D_Press,
    input  UpArrow_Press, RightArrow_Press, LeftArrow_Press, DownArrow_Press,
    input  Enter_Press, F_Press, R_Press, T_Press,
    input  rx_byte, rx_valid, frame_err
  );

  // Tracker side.
  modport slave (
    input  ps2_clk, ps2_data,
    output W_Press, A_Press, S_Press, D_Press,
    output UpArrow_Press, RightArrow_Press, LeftArrow_Press, DownArrow_Press,
    output Enter_Press, F_Press, R_Press, T_Press,
    output rx_byte, rx_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver and scan-code-set-2 decoder. Conditions the raw
// lines, assembles 11-bit frames, checks them, and keeps a held level for
// twelve game keys from make/break sequences.
module ps2_key_tracker #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input logic               clk,
  input logic               rst,
  ps2_key_tracker_if.slave  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // Key bit positions inside keys[].
  localparam logic [3:0] K_W = 4'd0,  K_A = 4'd1,  K_S = 4'd2,  K_D = 4'd3;
  localparam logic [3:0] K_UP = 4'd4, K_RT = 4'd5, K_LT = 4'd6, K_DN = 4'd7;
  localparam logic [3:0] K_EN = 4'd8, K_F = 4'd9,  K_R = 4'd10, K_T = 4'd11;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall, fall_dat;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [10:0]   shreg;
  logic [TW-1:0] tcnt;
  logic [7:0]    rx_byte_q;
  logic          rx_valid_q, frame_err_q;
  logic          frame_ok;

  logic          ext, brk;
  logic [11:0]   keys;
  logic          key_hit;
  logic [3:0]    key_idx;

  // Two-flop synchronizers; idle-high so reset matches an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;  clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_data; dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: follow the synced clock only after FILTER_LEN agreeing
  // samples; a 1->0 transition emits the sample strobe with the data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt     <= 1'b1;
      fcnt     <= '0;
      fall     <= 1'b0;
      fall_dat <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        fcnt     <= '0;
        fall     <= filt;
        fall_dat <= dat_s2;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Start low, stop high, odd parity over data plus parity bit.
  assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);

  // Frame receiver: IDLE takes the start bit, SHIFT collects bits 1..10
  // with an inactivity timeout, CHECK validates and strobes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tcnt        <= '0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall) begin
            shreg[0] <= fall_dat;
            bit_cnt  <= 4'd1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            shreg[bit_cnt] <= fall_dat;
            bit_cnt        <= bit_cnt + 4'd1;
            tcnt           <= '0;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (tcnt == TW'(TIMEOUT)) begin
            frame_err_q <= 1'b1;
            bit_cnt     <= '0;
            tcnt        <= '0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHECK: begin
          if (frame_ok) begin
            rx_byte_q  <= shreg[8:1];
            rx_valid_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
          bit_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan-code lookup; the E0 qualifier is part of the key so keypad codes
  // with the wrong prefix fall through as unmapped.
  always_comb begin
    key_hit = 1'b1;
    key_idx = K_W;
    case ({ext, rx_byte_q})
      9'h01D:  key_idx = K_W;
      9'h01C:  key_idx = K_A;
      9'h01B:  key_idx = K_S;
      9'h023:  key_idx = K_D;
      9'h05A:  key_idx = K_EN;
      9'h02B:  key_idx = K_F;
      9'h02D:  key_idx = K_R;
      9'h02C:  key_idx = K_T;
      9'h175:  key_idx = K_UP;
      9'h174:  key_idx = K_RT;
      9'h16B:  key_idx = K_LT;
      9'h172:  key_idx = K_DN;
      default: key_hit = 1'b0;
    endcase
  end

  // Make/break decoder: prefixes set flags, the final byte writes the key
  // level and consumes the flags; a bad frame abandons any pending prefix.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      keys <= '0;
    end else if (frame_err_q) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (rx_valid_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext <= 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        if (key_hit) keys[key_idx] <= ~brk;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign bus.W_Press          = keys[K_W];
  assign bus.A_Press          = keys[K_A];
  assign bus.S_Press          = keys[K_S];
  assign bus.D_Press          = keys[K_D];
  assign bus.UpArrow_Press    = keys[K_UP];
  assign bus.RightArrow_Press = keys[K_RT];
  assign bus.LeftArrow_Press  = keys[K_LT];
  assign bus.DownArrow_Press  = keys[K_DN];
  assign bus.Enter_Press      = keys[K_EN];
  assign bus.F_Press          = keys[K_F];
  assign bus.R_Press          = keys[K_R];
  assign bus.T_Press          = keys[K_T];
  assign bus.rx_byte          = rx_byte_q;
  assign bus.rx_valid         = rx_valid_q;
  assign bus.frame_err        = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a table of scan-code frames with
// expected key levels, then hand-written timeout, glitch and reset cases.
module tb_ps2_key_tracker;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_tracker_if bus ();

  ps2_key_tracker #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Key order: W A S D Up Right Left Down Enter F R T (bit 0..11).
  logic [11:0] keys_now;
  assign keys_now = {bus.T_Press, bus.R_Press, bus.F_Press, bus.Enter_Press,
                     bus.DownArrow_Press, bus.LeftArrow_Press,
                     bus.RightArrow_Press, bus.UpArrow_Press,
                     bus.D_Press, bus.S_Press, bus.A_Press, bus.W_Press};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int rv_cyc = 0, fe_cyc = 0, kchg_cyc = 0, last_fall = 0;
  logic [11:0] keys_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid)  begin rv_cnt++; rv_cyc = cyc; end
    if (bus.frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (bus.rx_valid && bus.frame_err) both_cnt++;
    if (keys_now !== keys_prev) begin kchg_cyc = cyc; keys_prev = keys_now; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] c, input logic flip);
    return {1'b1, (~(^c)) ^ flip, c, 1'b0};
  endfunction

  // Bit period 40 system cycles: data set, 10 high, 20 low, 10 high.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      repeat (10) @(posedge clk);
      bus.ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (20) @(posedge clk);
      bus.ps2_clk = 1'b1;
      repeat (10) @(posedge clk);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic flip);
    send_bits(mk(c, flip), 11);
    repeat (30) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0]  code;
    logic        flip;
    logic [11:0] keys;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int rv0, fe0, dw;
    logic [11:0] kexp;
    logic [7:0]  bexp;

    tbl[0]  = '{8'h1D, 1'b0, 12'h001};  // W make
    tbl[1]  = '{8'hF0, 1'b0, 12'h001};
    tbl[2]  = '{8'h1D, 1'b0, 12'h000};  // W break
    tbl[3]  = '{8'hE0, 1'b0, 12'h000};
    tbl[4]  = '{8'h75, 1'b0, 12'h010};  // Up make
    tbl[5]  = '{8'h75, 1'b0, 12'h010};  // keypad 8, unmapped
    tbl[6]  = '{8'hE0, 1'b0, 12'h010};
    tbl[7]  = '{8'hF0, 1'b0, 12'h010};
    tbl[8]  = '{8'h75, 1'b0, 12'h000};  // Up break
    tbl[9]  = '{8'h1C, 1'b0, 12'h002};  // A make
    tbl[10] = '{8'h2D, 1'b0, 12'h402};  // R make
    tbl[11] = '{8'hF0, 1'b0, 12'h402};
    tbl[12] = '{8'h1C, 1'b0, 12'h400};  // A break, R held
    tbl[13] = '{8'h2D, 1'b0, 12'h400};  // R typematic
    tbl[14] = '{8'h23, 1'b1, 12'h400};  // D, bad parity
    tbl[15] = '{8'h23, 1'b0, 12'h408};  // D make
    tbl[16] = '{8'hF0, 1'b0, 12'h408};
    tbl[17] = '{8'h1B, 1'b0, 12'h408};  // S break while not held
    tbl[18] = '{8'hE0, 1'b0, 12'h408};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_keys", 32'(keys_now), 32'h0);
    chk("reset_rx_byte", 32'(bus.rx_byte), 32'h0);
    chk("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'h0);

    kexp = '0;
    bexp = 8'h00;
    for (int i = 0; i < 19; i++) begin
      rv0 = rv_cnt; fe0 = fe_cnt;
      send_frame(tbl[i].code, tbl[i].flip);
      chk($sformatf("v%0d_keys", i), 32'(keys_now), 32'(tbl[i].keys));
      chk($sformatf("v%0d_rv", i), 32'(rv_cnt - rv0), tbl[i].flip ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_fe", i), 32'(fe_cnt - fe0), tbl[i].flip ? 32'd1 : 32'd0);
      if (!tbl[i].flip) bexp = tbl[i].code;
      chk($sformatf("v%0d_byte", i), 32'(bus.rx_byte), 32'(bexp));
      if (tbl[i].keys != kexp)
        chk($sformatf("v%0d_key_latency", i), 32'(kchg_cyc - rv_cyc), 32'd1);
      kexp = tbl[i].keys;
    end

    // Keypad Enter (E0 5A) must not set Enter.
    send_frame(8'h5A, 1'b0);
    chk("kp_enter_keys", 32'(keys_now), 32'h408);

    // Partial frame then silence: one timeout error, then a clean frame.
    rv0 = rv_cnt; fe0 = fe_cnt;
    send_bits(mk(8'h5A, 1'b0), 5);
    repeat (TIMEOUT + 60) @(posedge clk);
    chk("timeout_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("timeout_rv", 32'(rv_cnt - rv0), 32'd0);
    dw = fe_cyc - last_fall;
    chk("timeout_delay_ok", 32'(dw >= TIMEOUT + 1 && dw <= TIMEOUT + FILTER_LEN + 8), 32'd1);
    rv0 = rv_cnt; fe0 = fe_cnt;
    send_frame(8'h5A, 1'b0);
    chk("after_to_keys", 32'(keys_now), 32'h508);
    chk("after_to_rv", 32'(rv_cnt - rv0), 32'd1);
    chk("after_to_fe", 32'(fe_cnt - fe0), 32'd0);

    // Short clock glitch must not be taken as a start bit.
    rv0 = rv_cnt; fe0 = fe_cnt;
    bus.ps2_clk = 1'b0;
    repeat (FILTER_LEN - 4) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h2B, 1'b0);
    chk("glitch_keys", 32'(keys_now), 32'h708);
    chk("glitch_byte", 32'(bus.rx_byte), 32'h2B);
    chk("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("glitch_rv", 32'(rv_cnt - rv0), 32'd1);

    // Reset mid-frame while T is held.
    send_frame(8'h2C, 1'b0);
    chk("t_make_keys", 32'(keys_now), 32'hF08);
    send_bits(mk(8'h2D, 1'b0), 4);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_keys", 32'(keys_now), 32'h0);
    chk("midrst_byte", 32'(bus.rx_byte), 32'h0);
    chk("midrst_rv", 32'(bus.rx_valid), 32'h0);
    chk("midrst_fe", 32'(bus.frame_err), 32'h0);
    rv0 = rv_cnt; fe0 = fe_cnt;
    repeat (TIMEOUT + 50) @(posedge clk);
    send_frame(8'h2C, 1'b0);
    chk("post_rst_keys", 32'(keys_now), 32'h800);
    chk("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("post_rst_rv", 32'(rv_cnt - rv0), 32'd1);

    chk("rv_fe_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Receives the PS/2 keyboard serial stream, assembles and checks 11-bit frames, and decodes scan code set 2 make/break sequences. It holds a level-per-key pressed state for the twelve game keys: W, A, S, D, Up, Right, Left, Down, Enter, F, R and T. It sits directly upstream of the seven-segment input selector and drives its twelve `*_Press` inputs.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical samples of synchronized `ps2_clk` required before the filtered clock changes.
- `TIMEOUT`, default 20000: system clock cycles with no filtered falling edge, mid-frame, before the partial frame is aborted.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `W_Press`, `A_Press`, `S_Press`, `D_Press`  out  1 each  key held.
- `UpArrow_Press`, `RightArrow_Press`, `LeftArrow_Press`, `DownArrow_Press`  out  1 each  key held.
- `Enter_Press`, `F_Press`, `R_Press`, `T_Press`  out  1 each  key held.
- `rx_byte`  out  8  last correctly received byte.
- `rx_valid`  out  1  one-cycle strobe when `rx_byte` updates.
- `frame_err`  out  1  one-cycle strobe on a parity, start, stop or timeout error.

## Operation
Input conditioning:
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- The synchronized clock feeds a glitch filter. The filtered clock takes the sampled value only after `FILTER_LEN` identical consecutive samples.
- A falling edge of the filtered clock samples the synchronized data.

Receiver FSM:
- States: IDLE, SHIFT, CHECK.
- IDLE: the first falling edge samples the start bit, and the FSM enters SHIFT with bit count 1.
- SHIFT: each following edge stores data bits 0–7 (LSB first), then parity, then stop. The 11th bit moves the FSM to CHECK.
- CHECK lasts one cycle. The frame is valid when start=0, stop=1 and the 9 bits (data plus parity) contain an odd number of ones.
  - Valid frame: load `rx_byte` and pulse `rx_valid`.
  - Invalid frame: pulse `frame_err` and leave `rx_byte` unchanged.
  - Either way, return to IDLE.
- Timeout: the timeout counter clears on every filtered falling edge and counts while in SHIFT. When it reaches `TIMEOUT`, pulse `frame_err` and return to IDLE.

Decoder (acts on `rx_valid`):
- `E0`: set `ext`.
- `F0`: set `brk`.
- Any other byte:
  - If it maps to a key, write that key's bit to `!brk`.
  - In all cases, clear `ext` and `brk`.
- Key map:
  - Non-extended: W=1D, A=1C, S=1B, D=23, Enter=5A, F=2B, R=2D, T=2C.
  - Extended: Up=75, Right=74, Left=6B, Down=72.
- Bytes with the wrong `ext` qualifier are unmapped: keypad 75/74/6B/72 without E0, and keypad Enter E0 5A.
- Typematic repeats of a make code leave the bit at 1.
- A break code for a key that is not held leaves the bit at 0.
- Multiple keys may be held at once, and each bit is independent.
- A `frame_err` pulse clears `ext` and `brk`.

## Timing
- Reset (applies on any cycle, including mid-frame):
  - All twelve `*_Press` bits = 0.
  - `rx_byte` = 8'h00, `rx_valid` = 0, `frame_err` = 0.
  - FSM = IDLE, bit count = 0, `ext` = 0, `brk` = 0.
  - Filtered clock = 1, synchronizer flops = 1, timeout counter = 0.
  - Any partial frame is discarded. No strobe is produced for it after reset releases.
- Edge detection latency: 2 synchronizer cycles + `FILTER_LEN` cycles from a raw `ps2_clk` fall to the internal sample strobe.
- CHECK runs the cycle after the 11th sample strobe. `rx_valid` or `frame_err` is registered high in the following cycle, for exactly one cycle.
- `*_Press` changes exactly 1 cycle after the `rx_valid` cycle of the final byte of a sequence.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Test plan
- Frame 1D, then frames F0 1D → `W_Press` rises 1 cycle after the first `rx_valid` and falls 1 cycle after the `rx_valid` for 1D in the break sequence. No other bit changes.
- E0 75 → `UpArrow_Press`=1. Then a plain 75 → no output change. Then E0 F0 75 → `UpArrow_Press`=0.
- Hold 1C and 2D (make codes), then send F0 1C → `A_Press`=0 and `R_Press` stays 1. A repeated 2D make keeps `R_Press`=1.
- Frame 23 with the parity bit flipped → one `frame_err` pulse, no `rx_valid`, `D_Press` stays 0. The next good 23 frame → `D_Press`=1.
- Send 5 bits then stop clocking → `frame_err` pulses once, `TIMEOUT`+1 cycles after the last edge. The following full 5A frame → `Enter_Press`=1. A glitch on `ps2_clk` shorter than `FILTER_LEN` cycles → no bit is sampled.
- Assert `rst` for one cycle mid-frame while `T_Press`=1 → all outputs 0 on the next cycle. A fresh 2C frame after release → `T_Press`=1, with no spurious `frame_err`.
